// File: rtl/tm_pkg.sv
// Shared constants, state encoding and helpers for the clause vote datapath.
// Clause bank geometry, vote masks and sum/clamp parameters live here so the
// summer and the feedback logic agree on them.
package tm_pkg;

  localparam int CLAUSE_CHUNKS    = 63;
  localparam int REG_WIDTH        = 32;
  localparam int NUM_CLASSES      = 3;
  localparam int CHUNKS_PER_CLASS = 21;
  localparam int SUM_WIDTH        = 12;
  localparam int VOTE_T           = 100;

  localparam int ADDR_W  = 6;
  localparam int CLASS_W = 2;
  localparam int VOTE_W  = 6;
  localparam int IN_W    = $clog2(CHUNKS_PER_CLASS);

  // Even bit positions carry positive clauses, odd positions negative ones.
  localparam logic [31:0] POS_MASK = 32'h5555_5555;
  localparam logic [31:0] NEG_MASK = 32'hAAAA_AAAA;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DRAIN  = 3'd2,
    ARGMAX = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Saturate a class sum to [-VOTE_T, +VOTE_T].
  function automatic logic signed [SUM_WIDTH-1:0] clamp_sum(
    input logic signed [SUM_WIDTH-1:0] s
  );
    logic signed [SUM_WIDTH-1:0] hi;
    logic signed [SUM_WIDTH-1:0] lo;
    hi = SUM_WIDTH'(VOTE_T);
    lo = -hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/clause_vote_popcount.sv
// Combinational vote of one clause chunk: number of firing positive clauses
// minus number of firing negative clauses, as a signed value in -16..+16.
module clause_vote_popcount
  import tm_pkg::*;
(
  input  logic [REG_WIDTH-1:0]     word_i,
  output logic signed [VOTE_W-1:0] vote_o
);

  logic [REG_WIDTH-1:0] pos_bits;
  logic [REG_WIDTH-1:0] neg_bits;
  logic [VOTE_W-1:0]    pos_cnt;
  logic [VOTE_W-1:0]    neg_cnt;

  assign pos_bits = word_i & POS_MASK[REG_WIDTH-1:0];
  assign neg_bits = word_i & NEG_MASK[REG_WIDTH-1:0];

  // Count set bits in each polarity; counts never exceed REG_WIDTH/2.
  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int b = 0; b < REG_WIDTH; b++) begin
      pos_cnt = pos_cnt + VOTE_W'(pos_bits[b]);
      neg_cnt = neg_cnt + VOTE_W'(neg_bits[b]);
    end
  end

  // Both counts fit in 0..16, so the 6-bit difference is a valid signed vote.
  assign vote_o = signed'(pos_cnt - neg_cnt);

endmodule

// File: rtl/clause_vote_summer.sv
// Sweeps the clause output bank, accumulates one signed vote sum per class
// and picks the predicted class by argmax (ties go to the lowest index).
// Optional macro VOTE_CLAMP_EN: saturate each sum to [-VOTE_T, +VOTE_T]
// before argmax and output; when undefined the raw sums are used.
module clause_vote_summer
  import tm_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_flag_n,
  input  logic                             start,
  output logic                             read_mode,
  output logic [ADDR_W-1:0]                read_addr,
  input  logic [REG_WIDTH-1:0]             output_clause,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_CLASSES*SUM_WIDTH-1:0] class_sums,
  output logic [CLASS_W-1:0]               pred_class
);

  // Selector space is a power of two so argmax indexing never leaves the array.
  localparam int SEL_N = 1 << CLASS_W;

  state_e state_q, state_d;

  logic                             read_mode_q, read_mode_d;
  logic [ADDR_W-1:0]                read_addr_q, read_addr_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             rd_valid_q;
  logic [IN_W-1:0]                  in_cls_q, in_cls_d;
  logic [CLASS_W-1:0]               cls_q, cls_d;
  logic [CLASS_W-1:0]               arg_idx_q, arg_idx_d;
  logic [CLASS_W-1:0]               best_idx_q, best_idx_d;
  logic signed [SUM_WIDTH-1:0]      best_val_q, best_val_d;
  logic [CLASS_W-1:0]               pred_q, pred_d;
  logic [NUM_CLASSES*SUM_WIDTH-1:0] sums_out_q, sums_out_d;
  logic                             clear_acc;

  logic signed [VOTE_W-1:0]    vote;
  logic signed [SUM_WIDTH-1:0] vote_ext;
  logic signed [SUM_WIDTH-1:0] csum [SEL_N];
  logic signed [SUM_WIDTH-1:0] csum_sel;

  clause_vote_popcount u_popcount (
    .word_i (output_clause),
    .vote_o (vote)
  );

  assign vote_ext = {{(SUM_WIDTH-VOTE_W){vote[VOTE_W-1]}}, vote};

  genvar gi;
  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_cls
      if (gi < NUM_CLASSES) begin : g_acc
        logic signed [SUM_WIDTH-1:0] acc_q, acc_d;

        // Add the returning chunk's vote when it belongs to this class.
        always_comb begin
          acc_d = acc_q;
          if (clear_acc) begin
            acc_d = '0;
          end else if (rd_valid_q && (cls_q == CLASS_W'(gi))) begin
            acc_d = acc_q + vote_ext;
          end
        end

        // Class accumulator register.
        always_ff @(posedge clk) begin
          if (!rst_flag_n) acc_q <= '0;
          else             acc_q <= acc_d;
        end

`ifdef VOTE_CLAMP_EN
        assign csum[gi] = clamp_sum(acc_q);
`else
        assign csum[gi] = acc_q;
`endif
      end else begin : g_pad
        assign csum[gi] = '0;
      end
    end
  endgenerate

  assign csum_sel = csum[arg_idx_q];

  // Next-state and output logic of the sweep controller.
  always_comb begin
    state_d     = state_q;
    read_mode_d = read_mode_q;
    read_addr_d = read_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_cls_d    = in_cls_q;
    cls_d       = cls_q;
    arg_idx_d   = arg_idx_q;
    best_idx_d  = best_idx_q;
    best_val_d  = best_val_q;
    pred_d      = pred_q;
    sums_out_d  = sums_out_q;
    clear_acc   = 1'b0;

    // The class of the returning chunk follows the data, one step behind the
    // address: a chunk-in-class counter that rolls the class counter over.
    if (rd_valid_q) begin
      if (in_cls_q == IN_W'(CHUNKS_PER_CLASS-1)) begin
        in_cls_d = '0;
        cls_d    = cls_q + 1'b1;
      end else begin
        in_cls_d = in_cls_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // The done cycle is already IDLE; a start there is deliberately dropped.
        if (start && !done_q) begin
          state_d     = READ;
          clear_acc   = 1'b1;
          busy_d      = 1'b1;
          read_addr_d = '0;
          read_mode_d = 1'b1;
          in_cls_d    = '0;
          cls_d       = '0;
        end
      end
      READ: begin
        if (read_addr_q == ADDR_W'(CLAUSE_CHUNKS-1)) begin
          state_d     = DRAIN;
          read_mode_d = 1'b0;
        end else begin
          read_addr_d = read_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d   = ARGMAX;
        arg_idx_d = '0;
      end
      ARGMAX: begin
        if ((arg_idx_q == '0) || (csum_sel > best_val_q)) begin
          best_val_d = csum_sel;
          best_idx_d = arg_idx_q;
        end
        if (arg_idx_q == CLASS_W'(NUM_CLASSES-1)) begin
          state_d = DONE;
        end else begin
          arg_idx_d = arg_idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pred_d  = best_idx_q;
        for (int k = 0; k < NUM_CLASSES; k++) begin
          sums_out_d[k*SUM_WIDTH +: SUM_WIDTH] = csum[k];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (!rst_flag_n) begin
      state_q     <= IDLE;
      read_mode_q <= 1'b0;
      read_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      in_cls_q    <= '0;
      cls_q       <= '0;
      arg_idx_q   <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      pred_q      <= '0;
      sums_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      read_mode_q <= read_mode_d;
      read_addr_q <= read_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= read_mode_q;
      in_cls_q    <= in_cls_d;
      cls_q       <= cls_d;
      arg_idx_q   <= arg_idx_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      pred_q      <= pred_d;
      sums_out_q  <= sums_out_d;
    end
  end

  assign read_mode  = read_mode_q;
  assign read_addr  = read_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign class_sums = sums_out_q;
  assign pred_class = pred_q;

endmodule
